psum_collector: RTL and testbench
=================================

Name: psum_collector

Overview:
- Downstream of the systolic array: consumes its skewed bottom-row partial sums (ARRAYWIDTH columns, column c one cycle later than column c-1).
- Deskews the columns into one aligned row vector and accumulates rows across K-tiles in a row-indexed accumulator buffer.
- Pushes completed output rows into a small FIFO drained by a valid/ready consumer (output buffer / writeback).

Parameters:
- ARRAYWIDTH, 4, number of PE columns / psum lanes.
- PSUM_W, 32, width of one psum lane (matches the array output lane width).
- BASE_LAT, 4, cycles from an act_valid pulse to column 0's psum at in_psum (equals the array height for 1-cycle PEs).
- ACC_DEPTH, 16, accumulator rows (maximum rows per tile).
- FIFO_DEPTH, 4, output FIFO entries (power of two).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-low reset.
- act_valid, input, 1, an activation row entered the array this cycle.
- act_first_k, input, 1, qualifies act_valid: first K-tile, overwrite the accumulator row.
- act_last_k, input, 1, qualifies act_valid: final K-tile, emit the finished row.
- act_last_row, input, 1, qualifies act_valid: last row of the tile, row pointer returns to 0 afterwards.
- in_psum, input, ARRAYWIDTH*PSUM_W, array bottom-row psums; lane c is [c*PSUM_W +: PSUM_W].
- out_data, output, ARRAYWIDTH*PSUM_W, FIFO head, lane-aligned.
- out_valid, output, 1, FIFO non-empty.
- out_ready, input, 1, consumer accepts out_data when out_valid && out_ready.
- fifo_count, output, log2(FIFO_DEPTH)+1, current FIFO occupancy.
- overflow, output, 1, sticky: a finished row was dropped because the FIFO was full.

Behaviour:
- Reset (rst low, asynchronous): out_valid=0, fifo_count=0, overflow=0, out_data=0, row pointer=0, all tag and deskew pipelines cleared. Accumulator contents are don't-care.
- Tag pipeline:
  - {act_valid, first_k, last_k, last_row} shifts through a delay of L = BASE_LAT + ARRAYWIDTH - 1 registers.
  - An act_valid pulse at cycle t yields an aligned event at cycle t+L.
  - The qualifier inputs are ignored when act_valid=0.
- Deskew:
  - Lane c of in_psum passes through ARRAYWIDTH-1-c registers.
  - Lane ARRAYWIDTH-1 is used directly.
  - Lane c of a row arrives at t+BASE_LAT+c, so all lanes are aligned at t+L.
- Accumulate: on an aligned event at row pointer r:
  - sum = first_k ? aligned : acc[r] + aligned, per lane, modulo 2^PSUM_W (wrap, no saturation).
  - If last_k=0: acc[r] <= sum.
  - If last_k=1: sum is pushed to the FIFO; acc[r] is left unchanged.
  - first_k=1 with last_k=1 emits the aligned row directly (single-tile case).
- Row pointer: increments on each aligned event. It resets to 0 after an event with last_row=1, or after r=ACC_DEPTH-1 (wrap).
- Latency: an emitted row appears in the FIFO at t+L+1; with an empty FIFO, out_valid is high at t+L+1.
- FIFO:
  - Push and pop in the same cycle with the FIFO full: legal, and the push succeeds.
  - Push while full without a pop: the row is dropped, overflow is set to 1 and stays set until reset, fifo_count is unchanged.
  - Pop while empty: ignored.
  - out_data is held stable while out_valid && !out_ready.
- Backpressure:
  - The array cannot stall. The upstream controller must use fifo_count as a credit.
  - The block itself never stalls the tag or deskew pipelines.
- Back-to-back act_valid on every cycle is supported at full throughput.
- Reset asserted mid-operation: all in-flight tags and FIFO entries are discarded.

Test Plan:
- Single-tile deskew: ARRAYWIDTH=4, BASE_LAT=4; one act_valid with first_k=last_k=last_row=1 at cycle 0; drive lane c value 10+c only at cycle 4+c. Expect out_data lanes {10,11,12,13} with out_valid rising at cycle 8.
- Two-tile accumulate: 2 rows, lane value 1 in K-tile 0 (first_k) and 2 in K-tile 1 (last_k). Expect two outputs, each with all lanes = 3; row pointer wraps to 0 after each last_row.
- Wrap arithmetic: PSUM_W=32; K-tile 0 lane value 0xFFFFFFFF, K-tile 1 value 2. Expect output lane = 0x00000001.
- Overflow: out_ready=0, six single-tile emissions with FIFO_DEPTH=4. Expect fifo_count=4 and overflow=1; the first four rows drain in order once out_ready=1.
- Full with simultaneous pop: FIFO full, push and pop in the same cycle. Expect fifo_count to stay 4 and overflow to stay 0.
- Async reset: assert rst low mid-stream between clock edges. Expect out_valid=0, fifo_count=0 and overflow=0 immediately; no stale rows emerge after release.

Source files
------------

// File: rtl/psum_collector.sv
// Deskews the systolic array's bottom-row partial sums, accumulates them across K-tiles
// per output row, and queues finished rows in a small valid/ready FIFO.
module psum_collector #(
    parameter int ARRAYWIDTH = 4,
    parameter int PSUM_W     = 32,
    parameter int BASE_LAT   = 4,
    parameter int ACC_DEPTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           act_valid,
    input  logic                           act_first_k,
    input  logic                           act_last_k,
    input  logic                           act_last_row,
    input  logic [ARRAYWIDTH*PSUM_W-1:0]   in_psum,
    output logic [ARRAYWIDTH*PSUM_W-1:0]   out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic                           overflow
);

    localparam int L   = BASE_LAT + ARRAYWIDTH - 1;
    localparam int RPW = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;
    localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam int RW  = ARRAYWIDTH * PSUM_W;

    function automatic logic signed [PSUM_W-1:0] wrap_add(
        input logic signed [PSUM_W-1:0] a,
        input logic signed [PSUM_W-1:0] b
    );
        return a + b;
    endfunction

    logic [L-1:0] vld_p;
    logic [L-1:0] first_p;
    logic [L-1:0] lastk_p;
    logic [L-1:0] lastrow_p;

    logic                     ev_vld;
    logic                     ev_first;
    logic                     ev_last_k;
    logic                     ev_last_row;
    logic signed [PSUM_W-1:0] aligned [ARRAYWIDTH];
    logic signed [PSUM_W-1:0] sum     [ARRAYWIDTH];
    logic signed [PSUM_W-1:0] acc     [ACC_DEPTH][ARRAYWIDTH];
    logic [RW-1:0]            sum_flat;
    logic [RPW-1:0]           row_ptr;

    logic [RW-1:0]  fifo_mem [FIFO_DEPTH];
    logic [FAW-1:0] wr_ptr;
    logic [FAW-1:0] rd_ptr;
    logic           push_req;
    logic           push_ok;
    logic           pop;
    logic           full;

    // Stage p0..p(L-1): tag pipeline; qualifiers are masked so idle slots carry no flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p     <= '0;
            first_p   <= '0;
            lastk_p   <= '0;
            lastrow_p <= '0;
        end else begin
            vld_p[0]     <= act_valid;
            first_p[0]   <= act_valid & act_first_k;
            lastk_p[0]   <= act_valid & act_last_k;
            lastrow_p[0] <= act_valid & act_last_row;
            for (int i = 1; i < L; i++) begin
                vld_p[i]     <= vld_p[i-1];
                first_p[i]   <= first_p[i-1];
                lastk_p[i]   <= lastk_p[i-1];
                lastrow_p[i] <= lastrow_p[i-1];
            end
        end
    end

    assign ev_vld      = vld_p[L-1];
    assign ev_first    = first_p[L-1];
    assign ev_last_k   = lastk_p[L-1];
    assign ev_last_row = lastrow_p[L-1];

    // Deskew: earlier lanes wait longer so every lane lines up with the tag at stage L-1
    for (genvar c = 0; c < ARRAYWIDTH; c++) begin : g_lane
        localparam int D = ARRAYWIDTH - 1 - c;
        if (D == 0) begin : g_direct
            assign aligned[c] = in_psum[c*PSUM_W +: PSUM_W];
        end else begin : g_dly
            logic [PSUM_W-1:0] dly [D];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < D; i++) dly[i] <= '0;
                end else begin
                    dly[0] <= in_psum[c*PSUM_W +: PSUM_W];
                    for (int i = 1; i < D; i++) dly[i] <= dly[i-1];
                end
            end
            assign aligned[c] = dly[D-1];
        end
    end

    always_comb begin
        sum_flat = '0;
        for (int c = 0; c < ARRAYWIDTH; c++) begin
            sum[c] = ev_first ? aligned[c] : wrap_add(acc[row_ptr][c], aligned[c]);
            sum_flat[c*PSUM_W +: PSUM_W] = sum[c];
        end
    end

    // Final K-tile rows go straight to the FIFO and leave the accumulator row untouched
    always_ff @(posedge clk) begin
        if (ev_vld && !ev_last_k) begin
            for (int c = 0; c < ARRAYWIDTH; c++) acc[row_ptr][c] <= sum[c];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_ptr <= '0;
        end else if (ev_vld) begin
            if (ev_last_row || row_ptr == RPW'(ACC_DEPTH - 1)) row_ptr <= '0;
            else                                               row_ptr <= row_ptr + 1'b1;
        end
    end

    assign push_req  = ev_vld & ev_last_k;
    assign pop       = out_valid & out_ready;
    assign full      = (fifo_count == FCW'(FIFO_DEPTH));
    assign push_ok   = push_req & (~full | pop);
    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;

    // A push into a full FIFO overwrites the slot being popped in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + FCW'(push_ok) - FCW'(pop);
            if (push_req && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= sum_flat;
    end

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: deskew, K-tile accumulation, wrap, FIFO full/overflow
// handling and asynchronous reset, with cycle-indexed stimulus schedules.
module tb_psum_collector;

    localparam int AW = 4;
    localparam int PW = 32;
    localparam int NC = 256;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            act_valid = 1'b0;
    logic            act_first_k = 1'b0;
    logic            act_last_k = 1'b0;
    logic            act_last_row = 1'b0;
    logic [AW*PW-1:0] in_psum = '0;
    logic [AW*PW-1:0] out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [2:0]      fifo_count;
    logic            overflow;

    logic [3:0]      act_sched  [NC];
    logic [PW-1:0]   lane_sched [AW][NC];
    int              cyc;
    int              nvec;
    int              nerr;
    int              stale;

    always #5 clk = ~clk;

    psum_collector #(
        .ARRAYWIDTH(AW), .PSUM_W(PW), .BASE_LAT(4), .ACC_DEPTH(16), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .act_valid(act_valid), .act_first_k(act_first_k),
        .act_last_k(act_last_k), .act_last_row(act_last_row),
        .in_psum(in_psum), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_count(fifo_count), .overflow(overflow)
    );

    task automatic drive();
        if (cyc < NC) begin
            {act_valid, act_first_k, act_last_k, act_last_row} = act_sched[cyc];
            for (int c = 0; c < AW; c++) in_psum[c*PW +: PW] = lane_sched[c][cyc];
        end else begin
            {act_valid, act_first_k, act_last_k, act_last_row} = 4'b0000;
            in_psum = '0;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic run_to(input int t);
        while (cyc < t) next_cycle();
    endtask

    task automatic act(input int t, input logic f, input logic l, input logic r);
        act_sched[t] = {1'b1, f, l, r};
    endtask

    task automatic lanes(input int t, input logic [PW-1:0] v0, input logic [PW-1:0] v1,
                         input logic [PW-1:0] v2, input logic [PW-1:0] v3);
        lane_sched[0][t+4] = v0;
        lane_sched[1][t+5] = v1;
        lane_sched[2][t+6] = v2;
        lane_sched[3][t+7] = v3;
    endtask

    function automatic logic [127:0] row4(input logic [PW-1:0] v0, input logic [PW-1:0] v1,
                                          input logic [PW-1:0] v2, input logic [PW-1:0] v3);
        return {v3, v2, v1, v0};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nvec = 0;
        nerr = 0;
        cyc  = 0;
        for (int t = 0; t < NC; t++) begin
            act_sched[t] = 4'b0000;
            for (int c = 0; c < AW; c++) lane_sched[c][t] = 32'hA5A5_0000 + 32'(t * 16 + c);
        end
        act_sched[12] = 4'b0111;

        // single-tile deskew
        act(10, 1, 1, 1); lanes(10, 10, 11, 12, 13);
        // two-tile accumulate, two rows, back-to-back
        act(30, 1, 0, 0); lanes(30, 1, 1, 1, 1);
        act(31, 1, 0, 1); lanes(31, 1, 1, 1, 1);
        act(32, 0, 1, 0); lanes(32, 2, 2, 2, 2);
        act(33, 0, 1, 1); lanes(33, 2, 2, 2, 2);
        // wrap arithmetic
        act(50, 1, 0, 1); lanes(50, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        act(51, 0, 1, 1); lanes(51, 2, 3, 4, 5);
        // full with simultaneous pop, overflow, reset stream
        for (int i = 0; i < 5; i++) begin
            act(70 + i, 1, 1, 1);
            lanes(70 + i, 32'h100 * (i + 1), 32'h100 * (i + 1) + 1,
                  32'h100 * (i + 1) + 2, 32'h100 * (i + 1) + 3);
        end
        for (int i = 0; i < 6; i++) begin
            act(100 + i, 1, 1, 1);
            lanes(100 + i, 32'h1000 * (i + 1), 32'h1000 * (i + 1) + 1,
                  32'h1000 * (i + 1) + 2, 32'h1000 * (i + 1) + 3);
        end
        for (int i = 0; i < 6; i++) begin
            act(130 + i, 1, 1, 1);
            lanes(130 + i, 32'h7000 + i, 32'h7100 + i, 32'h7200 + i, 32'h7300 + i);
        end
        act(165, 1, 1, 1); lanes(165, 7, 8, 9, 10);

        drive();
        #2 rst = 1'b0;
        #1;
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_count", 128'(fifo_count), 128'(0));
        chk("rst_ovf",   128'(overflow), 128'(0));
        chk("rst_data",  out_data, 128'(0));
        next_cycle();
        next_cycle();
        rst = 1'b1;

        run_to(17);
        chk("t1_not_yet", 128'(out_valid), 128'(0));
        run_to(18);
        chk("t1_valid", 128'(out_valid), 128'(1));
        chk("t1_count", 128'(fifo_count), 128'(1));
        chk("t1_data",  out_data, row4(10, 11, 12, 13));
        out_ready = 1'b1;
        run_to(19);
        chk("t1_drained", 128'(fifo_count), 128'(0));
        out_ready = 1'b0;

        run_to(29);
        chk("idle_qual_ignored", 128'(fifo_count), 128'(0));
        run_to(41);
        chk("t2_count", 128'(fifo_count), 128'(2));
        chk("t2_row0",  out_data, row4(3, 3, 3, 3));
        out_ready = 1'b1;
        run_to(42);
        chk("t2_count1", 128'(fifo_count), 128'(1));
        chk("t2_row1",   out_data, row4(3, 3, 3, 3));
        run_to(43);
        chk("t2_empty",  128'(out_valid), 128'(0));

        run_to(59);
        chk("t3_valid", 128'(out_valid), 128'(1));
        chk("t3_wrap",  out_data, row4(1, 2, 3, 4));
        run_to(60);
        chk("t3_empty", 128'(fifo_count), 128'(0));
        out_ready = 1'b0;

        run_to(81);
        chk("t4_full",   128'(fifo_count), 128'(4));
        chk("t4_head0",  out_data, row4(32'h100, 32'h101, 32'h102, 32'h103));
        out_ready = 1'b1;
        run_to(82);
        out_ready = 1'b0;
        chk("t4_count_pp", 128'(fifo_count), 128'(4));
        chk("t4_ovf_pp",   128'(overflow), 128'(0));
        chk("t4_head1",    out_data, row4(32'h200, 32'h201, 32'h202, 32'h203));
        run_to(83);
        chk("t4_hold",     out_data, row4(32'h200, 32'h201, 32'h202, 32'h203));
        out_ready = 1'b1;
        run_to(84);
        chk("t4_head2", out_data, row4(32'h300, 32'h301, 32'h302, 32'h303));
        run_to(85);
        chk("t4_head3", out_data, row4(32'h400, 32'h401, 32'h402, 32'h403));
        run_to(86);
        chk("t4_head4", out_data, row4(32'h500, 32'h501, 32'h502, 32'h503));
        run_to(87);
        chk("t4_empty", 128'(fifo_count), 128'(0));
        out_ready = 1'b0;

        run_to(111);
        chk("t5_full",    128'(fifo_count), 128'(4));
        chk("t5_ovf_pre", 128'(overflow), 128'(0));
        run_to(113);
        chk("t5_count", 128'(fifo_count), 128'(4));
        chk("t5_ovf",   128'(overflow), 128'(1));
        chk("t5_head0", out_data, row4(32'h1000, 32'h1001, 32'h1002, 32'h1003));
        out_ready = 1'b1;
        run_to(114);
        chk("t5_head1", out_data, row4(32'h2000, 32'h2001, 32'h2002, 32'h2003));
        run_to(115);
        chk("t5_head2", out_data, row4(32'h3000, 32'h3001, 32'h3002, 32'h3003));
        run_to(116);
        chk("t5_head3", out_data, row4(32'h4000, 32'h4001, 32'h4002, 32'h4003));
        run_to(117);
        chk("t5_empty",  128'(out_valid), 128'(0));
        chk("t5_sticky", 128'(overflow), 128'(1));
        out_ready = 1'b0;

        run_to(139);
        chk("t6_pre_count", 128'(fifo_count), 128'(2));
        chk("t6_pre_head",  out_data, row4(32'h7000, 32'h7100, 32'h7200, 32'h7300));
        #2 rst = 1'b0;
        #1;
        chk("t6_valid", 128'(out_valid), 128'(0));
        chk("t6_count", 128'(fifo_count), 128'(0));
        chk("t6_ovf",   128'(overflow), 128'(0));
        run_to(140);
        rst = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        while (cyc < 160) begin
            next_cycle();
            if (out_valid) stale++;
        end
        chk("t6_no_stale", 128'(stale), 128'(0));
        out_ready = 1'b0;

        run_to(172);
        chk("t7_not_yet", 128'(out_valid), 128'(0));
        run_to(173);
        chk("t7_valid", 128'(out_valid), 128'(1));
        chk("t7_data",  out_data, row4(7, 8, 9, 10));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
